// File: rtl/game_sequencer_pkg.sv
// Shared definitions for the game sequencer and the blocks that decode its
// state (display and score logic).
//   game_state_t      : FSM state encoding, also the value on the 'state' port
//   *_DEF             : default frame-tick timings, life count and last level
//   ready_countdown() : maps elapsed READY ticks to the 3/2/1 seconds digit
package game_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_READY     = 3'd1,
        S_PLAY      = 3'd2,
        S_PAUSE     = 3'd3,
        S_DYING     = 3'd4,
        S_LEVEL_UP  = 3'd5,
        S_GAME_OVER = 3'd6,
        S_WIN       = 3'd7
    } game_state_t;

    localparam int TICK_W          = 8;
    localparam int READY_TICKS_DEF = 120;
    localparam int DYING_TICKS_DEF = 90;
    localparam int LIVES_INIT_DEF  = 3;
    localparam int MAX_LEVEL_DEF   = 9;

    // Splits the READY period into thirds: first third shows 3, second 2,
    // last 1. Compares ticks*3 against total so no divider is needed.
    function automatic logic [1:0] ready_countdown(input logic [7:0] ticks,
                                                   input logic [7:0] total);
        logic [9:0] t3;
        logic [9:0] tot;
        t3  = 10'(ticks) * 10'd3;
        tot = 10'(total);
        if (t3 < tot)
            return 2'd3;
        else if (t3 < (tot << 1))
            return 2'd2;
        else
            return 2'd1;
    endfunction

endpackage

// File: rtl/game_sequencer_tick_timer.sv
// tick_timer: loadable saturating frame-tick counter.
//   clk, rst     : clock, asynchronous active-low reset
//   clr          : force the count to zero (wins over en)
//   en           : count one tick this cycle
//   load/load_val: latch a new target value
//   count_next   : value the counter takes at the next edge
//   done         : this enabled tick is the target-th tick since the last clear
module tick_timer
    import game_sequencer_pkg::*;
#(
    parameter int W = TICK_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count_next,
    output logic         done
);

    localparam logic [W:0] ONE = {{W{1'b0}}, 1'b1};

    logic [W-1:0] count;
    logic [W-1:0] target;

    always_comb begin
        count_next = count;
        if (clr)
            count_next = '0;
        else if (en && (count != '1))
            count_next = count + ONE[W-1:0];
    end

    // done does not look at clr: the owner derives clr from done, and a
    // completed count is exactly what causes that clear.
    assign done = en && (({1'b0, count} + ONE) >= {1'b0, target});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            target <= '1;
        end else begin
            count <= count_next;
            if (load)
                target <= load_val;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: top-level game flow controller
// (IDLE/READY/PLAY/PAUSE/DYING/LEVEL_UP/GAME_OVER/WIN).
//   clk, rst    : clock, asynchronous active-low reset
//   tick        : one-cycle frame pulse
//   start/pause : one-cycle requests from the keypad / PS/2 decoder
//   crash       : level, pacman/ghost collision
//   beans_clear : level, bean map empty
//   state       : current FSM state (game_state_t encoding)
//   run_en      : high only in PLAY
//   respawn     : one-cycle pulse, characters return home
//   bean_reload : one-cycle pulse, bean map refills
//   lives, level, countdown, over, win : status for display and score
// Pulse semantics: respawn and bean_reload are registered, high for exactly
// the one cycle after the edge that makes the transition, with no handshake.
// Consumers must act on them in that cycle.
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int READY_TICKS = READY_TICKS_DEF,
    parameter int DYING_TICKS = DYING_TICKS_DEF,
    parameter int LIVES_INIT  = LIVES_INIT_DEF,
    parameter int MAX_LEVEL   = MAX_LEVEL_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic       crash,
    input  logic       beans_clear,
    output logic [2:0] state,
    output logic       run_en,
    output logic       respawn,
    output logic       bean_reload,
    output logic [1:0] lives,
    output logic [3:0] level,
    output logic [1:0] countdown,
    output logic       over,
    output logic       win
);

    localparam logic [7:0] READY_V      = 8'(READY_TICKS);
    localparam logic [7:0] DYING_V      = 8'(DYING_TICKS);
    localparam logic [1:0] LIVES_INIT_V = 2'(LIVES_INIT);
    localparam logic [3:0] MAX_LEVEL_V  = 4'(MAX_LEVEL);

    game_state_t cur;
    game_state_t nxt;

    logic       tmr_clr;
    logic       tmr_en;
    logic [7:0] tmr_load_val;
    logic [7:0] tmr_count_next;
    logic       tmr_done;

    assign state = cur;

    // Next-state decode. In PLAY, beans_clear beats crash, and crash beats
    // pause when several arrive together.
    always_comb begin
        nxt = cur;
        case (cur)
            S_IDLE, S_GAME_OVER, S_WIN:
                if (start) nxt = S_READY;
            S_READY:
                if (tmr_done) nxt = S_PLAY;
            S_PLAY:
                if (beans_clear)
                    nxt = (level >= MAX_LEVEL_V) ? S_WIN : S_LEVEL_UP;
                else if (crash)
                    nxt = S_DYING;
                else if (pause)
                    nxt = S_PAUSE;
            S_PAUSE:
                if (pause) nxt = S_PLAY;
            S_DYING:
                if (tmr_done) nxt = (lives == 2'd0) ? S_GAME_OVER : S_READY;
            S_LEVEL_UP:
                nxt = S_READY;
            default:
                nxt = S_IDLE;
        endcase
    end

    // Every state change restarts the count, so a tick arriving on the
    // transition cycle is not credited to the new state. The target is
    // loaded at the same time for whichever timed state is being entered.
    assign tmr_clr      = (nxt != cur);
    assign tmr_en       = tick && (cur != S_PAUSE);
    assign tmr_load_val = (nxt == S_DYING) ? DYING_V : READY_V;

    tick_timer #(.W(8)) u_tick_timer (
        .clk        (clk),
        .rst        (rst),
        .clr        (tmr_clr),
        .en         (tmr_en),
        .load       (tmr_clr),
        .load_val   (tmr_load_val),
        .count_next (tmr_count_next),
        .done       (tmr_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur         <= S_IDLE;
            lives       <= 2'd0;
            level       <= 4'd1;
            countdown   <= 2'd0;
            run_en      <= 1'b0;
            respawn     <= 1'b0;
            bean_reload <= 1'b0;
            over        <= 1'b0;
            win         <= 1'b0;
        end else begin
            cur         <= nxt;
            respawn     <= 1'b0;
            bean_reload <= 1'b0;
            run_en      <= (nxt == S_PLAY);
            over        <= (nxt == S_GAME_OVER);
            win         <= (nxt == S_WIN);
            countdown   <= (nxt == S_READY) ? ready_countdown(tmr_count_next, READY_V)
                                            : 2'd0;
            case (cur)
                S_IDLE, S_GAME_OVER, S_WIN:
                    if (nxt == S_READY) begin
                        lives       <= LIVES_INIT_V;
                        level       <= 4'd1;
                        respawn     <= 1'b1;
                        bean_reload <= 1'b1;
                    end
                S_PLAY:
                    if ((nxt == S_DYING) && (lives != 2'd0))
                        lives <= lives - 2'd1;
                S_DYING:
                    if (nxt == S_READY)
                        respawn <= 1'b1;
                S_LEVEL_UP: begin
                    if (level < MAX_LEVEL_V)
                        level <= level + 4'd1;
                    respawn     <= 1'b1;
                    bean_reload <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
module tb_game_sequencer;

  localparam int R_TICKS = 120;
  localparam int D_TICKS = 90;
  localparam int L_INIT  = 3;
  localparam int M_LEVEL = 9;

  localparam int ST_IDLE  = 0;
  localparam int ST_READY = 1;
  localparam int ST_PLAY  = 2;
  localparam int ST_PAUSE = 3;
  localparam int ST_DYING = 4;
  localparam int ST_LVLUP = 5;
  localparam int ST_OVER  = 6;
  localparam int ST_WIN   = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic crash = 1'b0;
  logic beans_clear = 1'b0;

  logic [2:0] state;
  logic       run_en;
  logic       respawn;
  logic       bean_reload;
  logic [1:0] lives;
  logic [3:0] level;
  logic [1:0] countdown;
  logic       over;
  logic       win;

  always #5 clk = ~clk;

  game_sequencer #(
    .READY_TICKS(R_TICKS),
    .DYING_TICKS(D_TICKS),
    .LIVES_INIT (L_INIT),
    .MAX_LEVEL  (M_LEVEL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .start      (start),
    .pause      (pause),
    .crash      (crash),
    .beans_clear(beans_clear),
    .state      (state),
    .run_en     (run_en),
    .respawn    (respawn),
    .bean_reload(bean_reload),
    .lives      (lives),
    .level      (level),
    .countdown  (countdown),
    .over       (over),
    .win        (win)
  );

  logic [15:0] act_vec;
  assign act_vec = {state, run_en, respawn, bean_reload, lives, level, countdown, over, win};

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  int m_st    = ST_IDLE;
  int m_cnt   = 0;
  int m_lives = 0;
  int m_level = 1;
  bit m_resp  = 1'b0;
  bit m_rel   = 1'b0;

  task automatic model_step(input bit r, input bit t, input bit s, input bit p,
                            input bit c, input bit b);
    int nxt;
    m_resp = 1'b0;
    m_rel  = 1'b0;
    if (!r) begin
      m_st = ST_IDLE; m_cnt = 0; m_lives = 0; m_level = 1;
      return;
    end
    nxt = m_st;
    case (m_st)
      ST_IDLE, ST_OVER, ST_WIN:
        if (s) begin
          nxt = ST_READY; m_lives = L_INIT; m_level = 1; m_resp = 1'b1; m_rel = 1'b1;
        end
      ST_READY:
        if (t && (m_cnt + 1 == R_TICKS)) nxt = ST_PLAY;
      ST_PLAY:
        if (b) nxt = (m_level == M_LEVEL) ? ST_WIN : ST_LVLUP;
        else if (c) begin
          nxt = ST_DYING;
          m_lives = (m_lives > 0) ? m_lives - 1 : 0;
        end else if (p) nxt = ST_PAUSE;
      ST_PAUSE:
        if (p) nxt = ST_PLAY;
      ST_DYING:
        if (t && (m_cnt + 1 == D_TICKS)) begin
          if (m_lives == 0) nxt = ST_OVER;
          else begin nxt = ST_READY; m_resp = 1'b1; end
        end
      ST_LVLUP: begin
        m_level = (m_level < M_LEVEL) ? m_level + 1 : M_LEVEL;
        m_resp = 1'b1; m_rel = 1'b1; nxt = ST_READY;
      end
      default: nxt = ST_IDLE;
    endcase
    if (nxt != m_st) m_cnt = 0;
    else if (t && m_st != ST_PAUSE && m_cnt < 255) m_cnt = m_cnt + 1;
    m_st = nxt;
  endtask

  function automatic logic [15:0] model_vec();
    int cd;
    cd = (m_st == ST_READY) ? 3 - (m_cnt * 3) / R_TICKS : 0;
    return {3'(m_st), (m_st == ST_PLAY), m_resp, m_rel, 2'(m_lives), 4'(m_level),
            2'(cd), (m_st == ST_OVER), (m_st == ST_WIN)};
  endfunction

  function automatic string fmt(input logic [15:0] v);
    return $sformatf("st=%0d run=%0d rsp=%0d rld=%0d lives=%0d lvl=%0d cd=%0d over=%0d win=%0d",
                     v[15:13], v[12], v[11], v[10], v[9:8], v[7:4], v[3:2], v[1], v[0]);
  endfunction

  task automatic check_vec(input string name, input logic [15:0] want);
    logic [15:0] got;
    got = act_vec;
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s @%0t: got %s, want %s", name, $time, fmt(got), fmt(want));
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_vec("outputs", e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit r, input bit t, input bit s, input bit p,
                       input bit c, input bit b);
    @(negedge clk); #1;
    rst = r; tick = t; start = s; pause = p; crash = c; beans_clear = b;
    model_step(r, t, s, p, c, b);
    exp_q.push_back(model_vec());
  endtask

  task automatic step(input bit t, input bit s, input bit p, input bit c, input bit b);
    drive(1'b1, t, s, p, c, b);
  endtask

  task automatic run_until(input int st, input int budget, input bit dense);
    int n;
    n = 0;
    while (m_st != st && n < budget) begin
      step(dense ? 1'b1 : bit'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    if (m_st != st) begin
      n_checks++;
      $display("FAIL timeout: state %0d not reached within %0d cycles", st, budget);
    end
  endtask

  // Reset asserted between edges must clear the outputs without waiting for clk.
  task automatic async_reset_check();
    @(negedge clk); #1;
    rst = 1'b0; tick = 1'b1; start = 1'b0; pause = 1'b0; crash = 1'b0; beans_clear = 1'b0;
    model_step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(model_vec());
    #1;
    check_vec("async_reset", model_vec());
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    // reset values
    repeat (3) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    // start, READY countdown, PLAY after tick 120 (tick on start not counted)
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    run_until(ST_PLAY, 400, 1'b1);
    repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // crash and beans_clear together: level up wins
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    run_until(ST_PLAY, 600, 1'b0);

    // pause, 50 ticks with ignored requests, resume
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++)
      step(1'b1, bit'(i % 7 == 0), 1'b0, bit'(i % 5 == 0), bit'(i % 11 == 0));
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // three crashes down to GAME_OVER
    for (int i = 0; i < 3; i++) begin
      run_until(ST_PLAY, 600, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      run_until((i == 2) ? ST_OVER : ST_READY, 400, 1'b0);
    end
    repeat (4) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    // climb to the last level and clear it
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int lv = 1; lv < M_LEVEL; lv++) begin
      run_until(ST_PLAY, 400, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    run_until(ST_PLAY, 400, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

    // reset mid-DYING with a tick pending
    run_until(ST_PLAY, 400, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    async_reset_check();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    // randomized play
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 799) == 0)
        drive(1'b0, bit'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0);
      else
        step(bit'($urandom_range(0, 1)),
             bit'($urandom_range(0, 15) == 0),
             bit'($urandom_range(0, 31) == 0),
             bit'($urandom_range(0, 63) == 0),
             bit'($urandom_range(0, 95) == 0));
    end

    // drain
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
